// File: rtl/shift_seq_if.sv
// shift_seq_if: start/busy/done handshake and operand/result bus for the shift sequencer.
interface shift_seq_if #(
    parameter int WIDTH = 32,
    parameter int SHW   = 5
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] a;
    logic [SHW-1:0]   shamt;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;

    modport master (output start, op, a, shamt, input busy, done, result);
    modport slave  (input start, op, a, shamt, output busy, done, result);
endinterface

// File: rtl/shift_seq.sv
// shift_seq: one-bit-per-cycle SLL/SRL/SRA sequencer with start/busy/done handshake.
module shift_seq #(
    parameter int WIDTH = 32,
    parameter int SHW   = 5
) (
    input  logic        clk,
    input  logic        rst_n,
    shift_seq_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t           state, state_n;
    logic [WIDTH-1:0] acc, acc_n, result_q;
    logic [SHW-1:0]   cnt, cnt_n;
    logic [1:0]       op_q, op_n;
    logic [WIDTH-1:0] step;

    // op_q[1] selects sign fill for SRA; SRL shifts in zero
    assign step = (op_q == 2'b00) ? {acc[WIDTH-2:0], 1'b0}
                                  : {op_q[1] & acc[WIDTH-1], acc[WIDTH-1:1]};

    always_comb begin
        state_n = state;
        acc_n   = acc;
        cnt_n   = cnt;
        op_n    = op_q;
        case (state)
            IDLE: if (bus.start) begin
                acc_n   = bus.a;
                op_n    = bus.op;
                cnt_n   = bus.shamt;
                state_n = (bus.shamt == '0 || bus.op == 2'b11) ? DONE : SHIFT;
            end
            SHIFT: begin
                acc_n   = step;
                cnt_n   = cnt - SHW'(1);
                state_n = (cnt == SHW'(1)) ? DONE : SHIFT;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            acc      <= '0;
            cnt      <= '0;
            op_q     <= '0;
            result_q <= '0;
        end else begin
            state <= state_n;
            acc   <= acc_n;
            cnt   <= cnt_n;
            op_q  <= op_n;
            // result only moves on entry to DONE, so it holds through IDLE and SHIFT
            if (state_n == DONE && state != DONE)
                result_q <= acc_n;
        end
    end

    assign bus.busy   = (state != IDLE);
    assign bus.done   = (state == DONE);
    assign bus.result = result_q;
endmodule

// File: tb/tb_shift_seq.sv
// tb_shift_seq: randomized and directed checks of shift_seq against a latency/arithmetic model.
module tb_shift_seq;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   failures = 0;
    bit   cmp_on = 1'b0;

    shift_seq_if #(.WIDTH(32), .SHW(5)) bus ();
    shift_seq #(.WIDTH(32), .SHW(5)) dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));

    always #5 clk = ~clk;

    // Model: result from plain arithmetic, done timing from a countdown of edges
    logic        m_busy, m_done;
    int          m_rem;
    logic [31:0] m_pend, m_res;

    function automatic logic [31:0] shift_ref(input logic [1:0] o, input logic [31:0] v, input logic [4:0] s);
        logic signed [31:0] sv;
        sv = v;
        case (o)
            2'b00:   return v << s;
            2'b01:   return v >> s;
            2'b10:   return sv >>> s;
            default: return v;
        endcase
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy = 0; m_done = 0; m_rem = 0; m_pend = '0; m_res = '0;
        end else if (m_done) begin
            m_done = 0; m_busy = 0;
        end else if (m_busy) begin
            m_rem = m_rem - 1;
            if (m_rem == 0) begin m_done = 1; m_res = m_pend; end
        end else if (bus.start) begin
            m_busy = 1;
            m_pend = shift_ref(bus.op, bus.a, bus.shamt);
            if (bus.shamt == 0 || bus.op == 2'b11) begin m_done = 1; m_res = m_pend; end
            else m_rem = int'(bus.shamt);
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) if (cmp_on) begin
        chk("model_busy", 32'(bus.busy), 32'(m_busy));
        chk("model_done", 32'(bus.done), 32'(m_done));
        chk("model_result", bus.result, m_res);
    end

    task automatic wait_idle();
        int n = 0;
        @(negedge clk);
        while (bus.busy && n < 100) begin @(negedge clk); n++; end
        if (n >= 100) chk("idle_timeout", 32'(bus.busy), 32'd0);
    endtask

    // lat: number of negedges after E0 at which done is expected (1 = cycle right after E0)
    task automatic run_op(input string nm, input logic [1:0] o, input logic [31:0] av,
                          input logic [4:0] s, input logic [31:0] exp, input int lat);
        int n = 0;
        bit got = 0;
        wait_idle();
        #1 bus.start = 1; bus.op = o; bus.a = av; bus.shamt = s;
        @(posedge clk);
        #1 bus.start = 0; bus.a = ~av; bus.op = ~o; bus.shamt = ~s;
        for (int i = 1; i <= 70 && !got; i++) begin
            @(negedge clk);
            if (bus.done) begin got = 1; n = i; end
        end
        chk({nm, "_latency"}, n, lat);
        chk({nm, "_result"}, bus.result, exp);
        @(negedge clk);
        chk({nm, "_pulse"}, 32'(bus.done), 32'd0);
    endtask

    initial begin
        int last_done;
        int dcount;
        int cyc;
        bus.start = 0; bus.op = 0; bus.a = 0; bus.shamt = 0;
        repeat (3) @(negedge clk);
        chk("reset_busy", 32'(bus.busy), 32'd0);
        chk("reset_done", 32'(bus.done), 32'd0);
        chk("reset_result", bus.result, 32'd0);
        #1 rst_n = 1;
        cmp_on = 1;

        run_op("sra31", 2'b10, 32'h8000_0000, 5'd31, 32'hFFFF_FFFF, 32);
        run_op("sra4",  2'b10, 32'h7FFF_FFF0, 5'd4,  32'h07FF_FFFF, 5);
        run_op("srl31", 2'b01, 32'h8000_0000, 5'd31, 32'h0000_0001, 32);
        run_op("sll31", 2'b00, 32'h0000_0001, 5'd31, 32'h8000_0000, 32);
        run_op("sra0",  2'b10, 32'hDEAD_BEEF, 5'd0,  32'hDEAD_BEEF, 1);
        run_op("pass7", 2'b11, 32'h1234_5678, 5'd7,  32'h1234_5678, 1);

        // Back-to-back: the first result must hold while the second is shifting
        run_op("sll4", 2'b00, 32'h0000_0001, 5'd4, 32'h0000_0010, 5);
        wait_idle();
        #1 bus.start = 1; bus.op = 2'b10; bus.a = 32'h80; bus.shamt = 5'd4;
        @(posedge clk);
        #1 bus.start = 0;
        @(negedge clk); @(negedge clk);
        chk("hold_prev_result", bus.result, 32'h0000_0010);
        wait_idle();
        chk("sra_0x80_by4", bus.result, 32'h0000_0008);

        // start held high: accepts every shamt+2 cycles; a changed mid-flight is ignored
        wait_idle();
        #1 bus.start = 1; bus.op = 2'b10; bus.a = 32'hF000_0000; bus.shamt = 5'd3;
        last_done = -1; dcount = 0; cyc = 0;
        while (dcount < 3 && cyc < 60) begin
            @(negedge clk);
            cyc++;
            if (bus.done) begin
                chk("held_result", bus.result, 32'hFE00_0000);
                if (last_done >= 0) chk("held_spacing", cyc - last_done, 32'd5);
                last_done = cyc;
                dcount++;
                if (dcount == 1) begin
                    @(negedge clk); @(negedge clk);
                    cyc += 2;
                    #1 bus.a = 32'h0;
                end else if (dcount == 2) begin
                    bus.start = 0;
                end
            end
        end
        chk("held_count", dcount, 32'd2 + 32'(dcount > 2));
        bus.start = 0;
        wait_idle();

        // Reset mid-SHIFT aborts immediately with no later done
        #1 bus.start = 1; bus.op = 2'b10; bus.a = 32'h8000_0000; bus.shamt = 5'd20;
        @(posedge clk);
        #1 bus.start = 0;
        repeat (5) @(negedge clk);
        #1 rst_n = 0;
        #1;
        chk("rst_mid_busy", 32'(bus.busy), 32'd0);
        chk("rst_mid_done", 32'(bus.done), 32'd0);
        chk("rst_mid_result", bus.result, 32'd0);
        @(negedge clk);
        #1 rst_n = 1;
        dcount = 0;
        repeat (30) begin @(negedge clk); if (bus.done) dcount++; end
        chk("no_done_after_reset", dcount, 32'd0);

        // Random traffic, including starts while busy and operand churn
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            #1;
            bus.start = ($urandom_range(0, 2) == 0);
            bus.op    = 2'($urandom);
            bus.a     = $urandom;
            case ($urandom_range(0, 5))
                0:       bus.shamt = 5'd0;
                1:       bus.shamt = 5'd31;
                default: bus.shamt = 5'($urandom_range(1, 8));
            endcase
        end
        bus.start = 0;
        wait_idle();
        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
